rotate_right_iter: RTL
======================

// Module: rotate_right_iter
// PURPOSE
//   Sequential, handshaked right-rotator: rotates an M-element word of N-bit
//   elements right by a runtime amount. It is the inverse of the static rotate-left
//   block: for a shift k in [0,M), rotate_right_iter(rotate_left(a,k),k) == a.
//   Uses log-step iteration: one 2^j-element stage per cycle, fixed latency.
//   Sits between a producer and consumer on valid/ready streams.
// PARAMETERS
//   M   4  number of N-bit elements per word (M >= 1)
//   N   8  width of each element in bits (N >= 1)
//   AW  localparam = (M > 1) ? $clog2(M) : 1; width of amt and step count
// PORTS
//   clk        in   1    clock, all state updates on rising edge
//   reset      in   1    asynchronous, active-high reset
//   in_valid   in   1    producer offers a and amt
//   in_ready   out  1    block can accept a transaction
//   a          in   N*M  input word; element i = a[N*i +: N]
//   amt        in   AW   right-rotate amount in elements (reduced mod M)
//   out_valid  out  1    y holds a completed result
//   out_ready  in   1    consumer accepts y
//   y          out  N*M  rotated word (registered)
//   busy       out  1    high in BUSY or DONE
// BEHAVIOUR
//   Function: s = amt % M. Element i of result = element (i+s)%M of a,
//     i.e. result = {a[0 +: N*s], a[N*s +: N*(M-s)]}. s=0 gives result = a.
//   Reset (async, active-high): state=IDLE, y=0, out_valid=0, busy=0, step=0.
//     in_ready is forced to 0 while reset is high.
//   FSM states IDLE, BUSY, DONE:
//     IDLE: in_ready=1. On in_valid&&in_ready: latch a into work reg,
//       latch s=amt%M, step=0, go to BUSY. Otherwise stay.
//     BUSY: in_ready=0. Each cycle: if bit step of s is set, work is rotated
//       right by (2^step)%M elements, else held. step++. After the step with
//       step==AW-1: y<=work result, out_valid<=1, go to DONE.
//     DONE: out_valid=1, in_ready=0. y is held stable while !out_ready.
//       On out_ready: out_valid<=0, go to IDLE.
//   Latency: out_valid rises exactly AW cycles after the accept edge.
//     Throughput: at most one transaction per AW+2 cycles.
//   in_valid, a and amt are ignored outside IDLE. out_ready is ignored outside DONE.
//   amt >= M, possible only when M is not a power of two, is reduced mod M before
//     stepping.
//   M=1: s is always 0; one no-op BUSY cycle; y=a.
//   Reset mid-BUSY or mid-DONE: the transaction is dropped silently. Outputs return
//     to reset values asynchronously, and no stale out_valid appears after reset
//     deasserts.
//   in_valid may be held high across transactions. A new accept happens only on a
//     cycle where the state is IDLE.
// TESTING
//   M=4,N=8: a=32'hDDCCBBAA, amt=1, out_ready=1 -> y=32'hAADDCCBB, out_valid
//     2 cycles after accept.
//   M=4,N=8: same a, amt=0 -> y=32'hDDCCBBAA. Same a, amt=3 -> y=32'hCCBBAADD.
//   M=3,N=4: a=12'hCBA, amt=3 -> y=12'hCBA (mod wrap). a=12'hCBA, amt=2 -> y=12'hBAC.
//   Backpressure: out_ready=0 for 5 cycles in DONE -> y and out_valid stable,
//     in_ready=0. Then out_ready=1 -> IDLE next cycle, in_ready=1.
//   Reset asserted in 2nd BUSY cycle (M=8) -> out_valid=0, y=0 immediately.
//     After release, a new transaction completes correctly.
//   Round trip: 1000 random a,k in [0,M) fed through rotate_left(R=k) then this
//     block with amt=k -> y==a, for M in {1,3,4,8}, N in {1,8}.

Source files
------------

// File: rtl/rotate_right_iter.sv
// rotate_right_iter
//   Sequential, handshaked right-rotator. It rotates an M-element word of N-bit
//   elements right by a runtime amount. It undoes a static rotate-left:
//   rotate_right_iter(rotate_left(a, k), k) == a for any k in [0, M).
//   The rotation is built one power-of-two stage per cycle: stage j rotates by
//   (2^j) % M elements when bit j of the reduced amount is set. Latency is fixed
//   at AW cycles from the accept edge to out_valid.
//
// Ports
//   clk        in   1     clock, all state updates on the rising edge
//   reset      in   1     asynchronous, active-high reset
//   in_valid   in   1     producer offers a and amt
//   in_ready   out  1     block can accept a transaction (IDLE, not in reset)
//   a          in   N*M   input word, element i = a[N*i +: N]
//   amt        in   AW    right-rotate amount in elements (reduced mod M)
//   out_valid  out  1     y holds a completed result
//   out_ready  in   1     consumer accepts y
//   y          out  N*M   rotated word (registered)
//   busy       out  1     high while a transaction is in BUSY or DONE
module rotate_right_iter #(
    parameter int M = 4,
    parameter int N = 8,
    localparam int AW = (M > 1) ? $clog2(M) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*M-1:0] a,
    input  logic [AW-1:0]  amt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*M-1:0] y,
    output logic           busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nx_s;
    logic [N*M-1:0] work_r;
    logic [N*M-1:0] work_nx_s;
    logic [AW-1:0]  s_r;
    logic [AW-1:0]  s_nx_s;
    logic [AW-1:0]  step_r;
    logic [AW-1:0]  step_nx_s;
    logic [N*M-1:0] y_r;
    logic [N*M-1:0] y_nx_s;
    logic           out_valid_r;
    logic           out_valid_nx_s;
    logic           busy_r;
    logic           busy_nx_s;

    logic [AW-1:0]  amt_mod_s;
    logic [N*M-1:0] stage_rot_s [AW];
    logic [N*M-1:0] sel_rot_s;
    logic           step_bit_s;
    logic [N*M-1:0] step_res_s;
    logic           last_step_s;

    // Amounts >= M can only occur when M is not a power of two; fold them here.
    always_comb begin
        amt_mod_s = AW'(32'(amt) % 32'(M));
    end

    // Each stage is a fixed element permutation of the work register, so the
    // rotate amount (2^j) % M is a constant per stage and needs no shifter.
    for (genvar j = 0; j < AW; j++) begin : g_stage
        for (genvar i = 0; i < M; i++) begin : g_elem
            assign stage_rot_s[j][N*i +: N] = work_r[N*((i + ((2 ** j) % M)) % M) +: N];
        end
    end

    // Pick the permutation and amount bit belonging to the current step.
    always_comb begin
        sel_rot_s  = '0;
        step_bit_s = 1'b0;
        for (int j = 0; j < AW; j++) begin
            sel_rot_s  = sel_rot_s  | ({(N*M){step_r == AW'(j)}} & stage_rot_s[j]);
            step_bit_s = step_bit_s | ((step_r == AW'(j)) & s_r[j]);
        end
        step_res_s  = step_bit_s ? sel_rot_s : work_r;
        last_step_s = (step_r == AW'(AW - 1));
    end

    // Next-state and next-register logic of the IDLE/BUSY/DONE handshake FSM.
    always_comb begin
        state_nx_s     = state_r;
        work_nx_s      = work_r;
        s_nx_s         = s_r;
        step_nx_s      = step_r;
        y_nx_s         = y_r;
        out_valid_nx_s = out_valid_r;
        busy_nx_s      = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    work_nx_s  = a;
                    s_nx_s     = amt_mod_s;
                    step_nx_s  = '0;
                    busy_nx_s  = 1'b1;
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                work_nx_s = step_res_s;
                step_nx_s = step_r + AW'(1);
                if (last_step_s) begin
                    y_nx_s         = step_res_s;
                    out_valid_nx_s = 1'b1;
                    state_nx_s     = ST_DONE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_nx_s = 1'b0;
                    busy_nx_s      = 1'b0;
                    state_nx_s     = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                out_valid_nx_s = 1'b0;
                busy_nx_s      = 1'b0;
                state_nx_s     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            work_r      <= '0;
            s_r         <= '0;
            step_r      <= '0;
            y_r         <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            work_r      <= work_nx_s;
            s_r         <= s_nx_s;
            step_r      <= step_nx_s;
            y_r         <= y_nx_s;
            out_valid_r <= out_valid_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    // in_ready follows reset directly so it is low for the whole reset pulse.
    assign in_ready  = (state_r == ST_IDLE) && !reset;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign busy      = busy_r;

endmodule
